uart_tx_param: RTL

Parametrised UART transmitter. Successor to the fixed 8-bit, free-running transmitter.
- Serialises a DATA_W-bit word as start bit, LSB-first data, optional parity and 1 or 2 stop bits.
- Configurable baud divider.
- Adds a valid/ready handshake, busy/done status and reset-safe abort.
- Sits between the system-side data source and the serial line, opposite the UART receiver.

---
 rtl/uart_tx_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready handshake.
// Frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the data bits
// (even parity, or odd parity when PARITY_ODD=1). Without it PARITY_ODD is unused.
module uart_tx_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic [DATA_W-1:0] data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_out_d, tx_ready_d, tx_busy_d, tx_done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // State, counters, shift register and registered outputs
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_out   <= tx_out_d;
      tx_ready <= tx_ready_d;
      tx_busy  <= tx_busy_d;
      tx_done  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, counter and next-output logic; line level is chosen one cycle ahead
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_out_d  = tx_out;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    bit_end   = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_out_d = 1'b1;
        if (tx_valid && tx_ready) begin
          state_d  = S_START;
          shift_d  = data;
          baud_d   = '0;
          idx_d    = '0;
          tx_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          idx_d    = '0;
          tx_out_d = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = S_PARITY;
            tx_out_d = parity_q;
`else
            state_d  = S_STOP;
            tx_out_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            shift_d  = shift_q >> 1;
            tx_out_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          idx_d    = '0;
          tx_out_d = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_out_d = 1'b1;
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            tx_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_out_d = 1'b1;
      end
    endcase

    tx_ready_d = (state_d == S_IDLE);
    tx_busy_d  = ~tx_ready_d;
  end

endmodule
